// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: the write-back request from the stage register,
// the two decode read ports, and the commit/debug observation outputs.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  // No backpressure on this bus. A write is accepted on the rising edge when
  // wb_valid & reg_write are high and write_reg != 0. wb_commit pulses for
  // exactly one cycle after each accepted write. Reads are combinational.
  logic              wb_valid;
  logic              reg_write;
  logic              mem_to_reg;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output wb_valid, reg_write, mem_to_reg, write_reg, read_data, alu_result,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_commit, retire_cnt
  );

  modport slave (
    input  wb_valid, reg_write, mem_to_reg, write_reg, read_data, alu_result,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_commit, retire_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry general-purpose register file with a retired-write counter.
// Optional macro WB_BYPASS_EN: write-through from the write-back value to both read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wb_val;
  logic              we;
  logic              commit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign wb_val = bus.mem_to_reg ? bus.read_data : bus.alu_result;
  assign we     = bus.wb_valid & bus.reg_write & (bus.write_reg != 5'd0);

  // r0 is never written because we excludes index 0, so it stays at its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[bus.write_reg] <= wb_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      commit_q <= we;
      if (we) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (bus.rs_addr != 5'd0) begin
      rs_val = regs[bus.rs_addr];
    end
    if (bus.rt_addr != 5'd0) begin
      rt_val = regs[bus.rt_addr];
    end
`ifdef WB_BYPASS_EN
    // Reset masks the bypass so both ports still read 0 while reset is held.
    if (we && !reset && (bus.rs_addr == bus.write_reg)) begin
      rs_val = wb_val;
    end
    if (we && !reset && (bus.rt_addr == bus.write_reg)) begin
      rt_val = wb_val;
    end
`endif
  end

  assign bus.rs_data    = rs_val;
  assign bus.rt_data    = rt_val;
  assign bus.wb_data    = wb_val;
  assign bus.wb_commit  = commit_q;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference register model, expected-value
// queue for read ports, and a second instance with a 4-bit counter for wrap.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic reset;

  wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_regs [32];
  logic [31:0] exp_cnt;
  logic        exp_commit;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] want;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] wr,
                       input logic [31:0] rd, input logic [31:0] alu);
    bus.wb_valid   = v;
    bus.reg_write  = rw;
    bus.mem_to_reg = m2r;
    bus.write_reg  = wr;
    bus.read_data  = rd;
    bus.alu_result = alu;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Clock one edge and advance the reference model from the stimulus currently driven.
  task automatic step();
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    w = bus.wb_valid & bus.reg_write & (bus.write_reg != 5'd0);
    a = bus.write_reg;
    d = bus.mem_to_reg ? bus.read_data : bus.alu_result;
    @(posedge clk);
    #1;
    if (w) begin
      exp_regs[a] = d;
      exp_cnt     = exp_cnt + 32'd1;
    end
    exp_commit = w;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic w,
                                           input logic [4:0] wr, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && w && (a == wr)) return d;
    return exp_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_cnt    = 32'd0;
    exp_commit = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // power-on reset
    n_cmp++; if (bus.retire_cnt !== 32'd0) begin n_err++; $display("FAIL por_cnt: got %h expected %h", bus.retire_cnt, 32'd0); end
    n_cmp++; if (bus.wb_commit !== 1'b0) begin n_err++; $display("FAIL por_commit: got %b expected 0", bus.wb_commit); end
    @(negedge clk); reset = 1'b0;
    model_clear();
    // preload r3, r4
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0000_0033); step();
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0044, 32'h0); step();
    @(negedge clk); idle(); bus.rs_addr = 5'd3; bus.rt_addr = 5'd4;
    #1;
    n_cmp++; if (bus.rs_data !== 32'h33) begin n_err++; $display("FAIL preload_r3: got %h expected %h", bus.rs_data, 32'h33); end
    // mid-cycle asynchronous reset, with a write request present
    @(posedge clk); #2;
    drive(1'b1, 1'b1, 1'b0, 5'd10, 32'h0, 32'hCAFE_0010);
    bus.rt_addr = 5'd10;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.rs_data !== 32'd0) begin n_err++; $display("FAIL rst_rs: got %h expected %h", bus.rs_data, 32'd0); end
    n_cmp++; if (bus.rt_data !== 32'd0) begin n_err++; $display("FAIL rst_rt: got %h expected %h", bus.rt_data, 32'd0); end
    n_cmp++; if (bus.retire_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %h expected %h", bus.retire_cnt, 32'd0); end
    n_cmp++; if (bus.wb_commit !== 1'b0) begin n_err++; $display("FAIL rst_commit: got %b expected 0", bus.wb_commit); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rt_data !== 32'd0) begin n_err++; $display("FAIL rst_write_ignored: got %h expected %h", bus.rt_data, 32'd0); end
    n_cmp++; if (bus.retire_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt_held: got %h expected %h", bus.retire_cnt, 32'd0); end
    @(negedge clk); idle(); reset = 1'b0;
    model_clear();
  endtask

  task automatic test_source_select();
    logic [31:0] c0;
    c0 = exp_cnt;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0000_00AA);
    #1;
    n_cmp++; if (bus.wb_data !== 32'h0000_00AA) begin n_err++; $display("FAIL sel_alu: got %h expected %h", bus.wb_data, 32'hAA); end
    step();
    n_cmp++; if (bus.wb_commit !== 1'b1) begin n_err++; $display("FAIL sel_commit1: got %b expected 1", bus.wb_commit); end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h1234_5678, 32'h0000_00AA);
    #1;
    n_cmp++; if (bus.wb_data !== 32'h1234_5678) begin n_err++; $display("FAIL sel_mem: got %h expected %h", bus.wb_data, 32'h1234_5678); end
    step();
    n_cmp++; if (bus.wb_commit !== 1'b1) begin n_err++; $display("FAIL sel_commit2: got %b expected 1", bus.wb_commit); end
    @(negedge clk); idle();
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd6;
    exp_q.push_back(32'h0000_00AA);
    exp_q.push_back(32'h1234_5678);
    #1;
    want = exp_q.pop_front(); got = bus.rs_data;
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL sel_rd_r5: got %h expected %h", got, want); end
    want = exp_q.pop_front(); got = bus.rt_data;
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL sel_rd_r6: got %h expected %h", got, want); end
    n_cmp++; if (bus.retire_cnt !== c0 + 32'd2) begin n_err++; $display("FAIL sel_cnt: got %h expected %h", bus.retire_cnt, c0 + 32'd2); end
    step();
    n_cmp++; if (bus.wb_commit !== 1'b0) begin n_err++; $display("FAIL sel_commit_drop: got %b expected 0", bus.wb_commit); end
  endtask

  task automatic test_r0();
    logic [31:0] c0;
    c0 = exp_cnt;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    #1;
    n_cmp++; if (bus.rs_data !== 32'd0) begin n_err++; $display("FAIL r0_same_cycle: got %h expected %h", bus.rs_data, 32'd0); end
    step();
    n_cmp++; if (bus.wb_commit !== 1'b0) begin n_err++; $display("FAIL r0_commit: got %b expected 0", bus.wb_commit); end
    n_cmp++; if (bus.retire_cnt !== c0) begin n_err++; $display("FAIL r0_cnt: got %h expected %h", bus.retire_cnt, c0); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.rs_data !== 32'd0) begin n_err++; $display("FAIL r0_read: got %h expected %h", bus.rs_data, 32'd0); end
    n_cmp++; if (bus.rt_data !== 32'd0) begin n_err++; $display("FAIL r0_read_rt: got %h expected %h", bus.rt_data, 32'd0); end
  endtask

  task automatic test_gating();
    logic [31:0] c0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h0000_0077); step();
    c0 = exp_cnt;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'hDEAD_0001);
    bus.rs_addr = 5'd7;
    #1;
    n_cmp++; if (bus.rs_data !== 32'h77) begin n_err++; $display("FAIL gate_nv_bypass: got %h expected %h", bus.rs_data, 32'h77); end
    step();
    n_cmp++; if (bus.wb_commit !== 1'b0) begin n_err++; $display("FAIL gate_nv_commit: got %b expected 0", bus.wb_commit); end
    n_cmp++; if (bus.retire_cnt !== c0) begin n_err++; $display("FAIL gate_nv_cnt: got %h expected %h", bus.retire_cnt, c0); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'hDEAD_0002);
    step();
    @(negedge clk); idle(); bus.rt_addr = 5'd7;
    exp_q.push_back(exp_regs[7]);
    #1;
    want = exp_q.pop_front(); got = bus.rt_data;
    n_cmp++; if (got !== want) begin n_err++; $display("FAIL gate_r7: got %h expected %h", got, want); end
    n_cmp++; if (bus.retire_cnt !== c0) begin n_err++; $display("FAIL gate_nrw_cnt: got %h expected %h", bus.retire_cnt, c0); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_0011); step();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_0022);
    bus.rs_addr = 5'd9; bus.rt_addr = 5'd9;
    want = BYPASS ? 32'h22 : 32'h11;
    #1;
    n_cmp++; if (bus.rs_data !== want) begin n_err++; $display("FAIL byp_rs_pre: got %h expected %h", bus.rs_data, want); end
    n_cmp++; if (bus.rt_data !== want) begin n_err++; $display("FAIL byp_rt_pre: got %h expected %h", bus.rt_data, want); end
    step();
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.rs_data !== 32'h22) begin n_err++; $display("FAIL byp_rs_post: got %h expected %h", bus.rs_data, 32'h22); end
    n_cmp++; if (bus.rt_data !== 32'h22) begin n_err++; $display("FAIL byp_rt_post: got %h expected %h", bus.rt_data, 32'h22); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus4.wb_valid = 1'b1; bus4.reg_write = 1'b1; bus4.mem_to_reg = 1'b0;
      bus4.write_reg = 5'd1; bus4.alu_result = 32'(i + 100);
      @(posedge clk); #1;
      if (i == 15) begin
        n_cmp++; if (bus4.retire_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %h expected %h", bus4.retire_cnt, 4'd0); end
      end
    end
    @(negedge clk);
    bus4.wb_valid = 1'b0; bus4.reg_write = 1'b0; bus4.rs_addr = 5'd1;
    #1;
    n_cmp++; if (bus4.retire_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_17: got %h expected %h", bus4.retire_cnt, 4'd1); end
    n_cmp++; if (bus4.rs_data !== 32'd116) begin n_err++; $display("FAIL wrap_r1: got %h expected %h", bus4.rs_data, 32'd116); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  prev_wr;
    logic        w;
    logic [31:0] d;
    prev_wr = 5'd5;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, $urandom);
      bus.rs_addr = prev_wr;
      bus.rt_addr = ($urandom_range(0, 3) == 0) ? bus.write_reg : 5'($urandom_range(0, 31));
      w = bus.wb_valid & bus.reg_write & (bus.write_reg != 5'd0);
      d = bus.mem_to_reg ? bus.read_data : bus.alu_result;
      exp_q.push_back(exp_read(bus.rs_addr, w, bus.write_reg, d));
      exp_q.push_back(exp_read(bus.rt_addr, w, bus.write_reg, d));
      #1;
      n_cmp++; if (bus.wb_data !== d) begin n_err++; $display("FAIL b2b_wb_data[%0d]: got %h expected %h", i, bus.wb_data, d); end
      want = exp_q.pop_front(); got = bus.rs_data;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b_rs[%0d]: got %h expected %h", i, got, want); end
      want = exp_q.pop_front(); got = bus.rt_data;
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b_rt[%0d]: got %h expected %h", i, got, want); end
      prev_wr = bus.write_reg;
      step();
      n_cmp++; if (bus.wb_commit !== exp_commit) begin n_err++; $display("FAIL b2b_commit[%0d]: got %b expected %b", i, bus.wb_commit, exp_commit); end
      n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %h expected %h", i, bus.retire_cnt, exp_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    bus4.wb_valid = 1'b0; bus4.reg_write = 1'b0; bus4.mem_to_reg = 1'b0;
    bus4.write_reg = 5'd0; bus4.read_data = 32'd0; bus4.alu_result = 32'd0;
    bus4.rs_addr = 5'd0; bus4.rt_addr = 5'd0;
    model_clear();
    #3;
    test_reset();
    test_source_select();
    test_r0();
    test_gating();
    test_bypass();
    test_wrap();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d expected 0 entries left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface: consumes the stage register's mem_to_reg select, load data and ALU result, forms the write-back value, and commits it to a 32x32 general-purpose register file.
- Provides the two combinational read ports used by decode.
- Keeps a retired-write counter for debug and performance.
- Sits between the MEM/WB pipeline register and the ID stage.

Parameters:
- DATA_W, 32, register and data width in bits.
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  pipeline clock, rising-edge active.
- reset  input  1  asynchronous active-high reset.
- wb_valid  input  1  a valid instruction occupies the WB stage this cycle.
- reg_write  input  1  instruction writes a register.
- mem_to_reg  input  1  1 selects read_data, 0 selects alu_result.
- write_reg  input  5  destination register index.
- read_data  input  DATA_W  load data from the MEM/WB register.
- alu_result  input  DATA_W  ALU result from the MEM/WB register.
- rs_addr  input  5  read port A index.
- rt_addr  input  5  read port B index.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wb_data  output  DATA_W  selected write-back value; combinational.
- wb_commit  output  1  registered pulse: a register was written on the previous edge.
- retire_cnt  output  CNT_W  count of committed register writes.

Behaviour:
- Reset is asynchronous: on assertion of reset, all NREGS registers clear to 0, wb_commit clears to 0 and retire_cnt clears to 0, independent of clk.
- While reset is high, writes are ignored.
- Because the registers are 0, rs_data and rt_data read 0 during reset.
- wb_data = mem_to_reg ? read_data : alu_result. It is purely combinational and is valid regardless of wb_valid.
- Write enable we = wb_valid & reg_write & (write_reg != 0).
- On each rising clk with we=1, regs[write_reg] <= wb_data. The register is updated one edge after the inputs are presented.
- Register 0 is hardwired to 0. Writes to index 0 are dropped and are not counted.
- wb_commit <= we on every edge, so it is high for exactly one cycle after each committed write.
- retire_cnt increments by 1 on every edge where we=1 and wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Read ports are combinational: rs_data = regs[rs_addr] and rt_data = regs[rt_addr]. An index of 0 always returns 0.
- Same-cycle read/write of one register: behaviour is governed by WB_BYPASS_EN (see Optional Feature).
- Both read ports may address the same register; both return the identical value.
- Inputs are not sampled on edges where reset is asserted. The first edge after reset deasserts behaves normally.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: write-through. If we=1 and rs_addr == write_reg, rs_data = wb_data in the same cycle; the rt port follows the same rule. This removes the half-cycle write-before-read hazard from the three-instruction distance.
- Undefined: reads return the stored register contents only. The new value becomes visible after the next rising edge, and the hazard must be covered by the forwarding unit or by a stall.

Test Plan:
- Reset: assert reset mid-cycle with regs preloaded -> immediately rs_data = rt_data = 0, retire_cnt = 0, wb_commit = 0 for any address.
- Source select: wb_valid=1, reg_write=1, write_reg=5, mem_to_reg=0, alu_result=0x0000_00AA, read_data=0x1234_5678, then on the next cycle mem_to_reg=1, write_reg=6 -> rs_addr=5 reads 0xAA and rt_addr=6 reads 0x1234_5678; retire_cnt=2; wb_commit is high for two consecutive cycles.
- Write to r0: write_reg=0, alu_result=0xFFFF_FFFF, reg_write=1 -> rs_addr=0 reads 0; retire_cnt unchanged; wb_commit=0.
- Gating: reg_write=1 with wb_valid=0, write_reg=7 -> r7 unchanged and no count; then wb_valid=1 with reg_write=0 -> r7 still unchanged.
- Bypass: r9 holds 0x11; present write of 0x22 to r9 with rs_addr=rt_addr=9 in the same cycle. With WB_BYPASS_EN defined, both ports read 0x22 before the edge. Without it, both ports read 0x11 before the edge and 0x22 after.
- Counter wrap: with CNT_W=4, perform 17 valid writes to r1 -> retire_cnt = 1.
